// File: rtl/udp_line_packer.sv
// Packs one buffered camera line into a byte stream: a 4-byte line header, then
// each 16-bit pixel MSB first, with a valid/ready handshake toward the UDP path.
module udp_line_packer #(
    parameter int H_ACT = 1280
) (
    input  logic        rclk,
    input  logic        rstn,
    input  logic        aquire,
    output logic        read_en,
    input  logic [15:0] cam_data,
    input  logic [10:0] cam_row,
    input  logic [4:0]  cam_id,
    input  logic        up_error,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic [15:0] tx_len,
    output logic        busy,
    output logic [15:0] line_cnt,
    output logic        err_sticky
);

    localparam int          HDR_BYTES = 4;
    localparam logic [15:0] HACT16    = 16'(H_ACT);
    localparam logic [10:0] LAST_PIX  = 11'(H_ACT - 1);

    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, PAY_HI, PAY_LO} state_t;

    state_t      state_q, state_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] pix_q, pix_d;
    logic [10:0] row_q, row_d;
    logic [4:0]  id_q, id_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        err_q;

    assign tx_len     = 16'(HDR_BYTES + 2 * H_ACT);
    assign line_cnt   = line_cnt_q;
    assign err_sticky = err_q;

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            byte_idx_q <= '0;
            pix_q      <= '0;
            row_q      <= '0;
            id_q       <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            byte_idx_q <= byte_idx_d;
            pix_q      <= pix_d;
            row_q      <= row_d;
            id_q       <= id_d;
            line_cnt_q <= line_cnt_d;
            err_q      <= err_q | up_error;
        end
    end

    // tx_valid is constant within HDR/PAY_HI/PAY_LO, so tx_ready alone marks a handshake there.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        byte_idx_d = byte_idx_q;
        pix_d      = pix_q;
        row_d      = row_q;
        id_d       = id_q;
        line_cnt_d = line_cnt_q;
        case (state_q)
            IDLE: if (aquire) begin
                row_d      = cam_row;
                id_d       = cam_id;
                pix_cnt_d  = '0;
                byte_idx_d = '0;
                state_d    = HDR;
            end
            HDR: if (tx_ready) begin
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) state_d = FETCH;
            end
            FETCH:  state_d = LATCH;
            LATCH: begin
                pix_d   = cam_data;
                state_d = PAY_HI;
            end
            PAY_HI: if (tx_ready) state_d = PAY_LO;
            PAY_LO: if (tx_ready) begin
                if (pix_cnt_q == LAST_PIX) begin
                    line_cnt_d = line_cnt_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    pix_cnt_d = pix_cnt_q + 11'd1;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_en  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                case (byte_idx_q)
                    2'd0:    tx_data = {id_q, row_q[10:8]};
                    2'd1:    tx_data = row_q[7:0];
                    2'd2:    tx_data = HACT16[15:8];
                    default: tx_data = HACT16[7:0];
                endcase
            end
            FETCH:  read_en = 1'b1;
            PAY_HI: begin
                tx_valid = 1'b1;
                tx_data  = pix_q[15:8];
            end
            PAY_LO: begin
                tx_valid = 1'b1;
                tx_data  = pix_q[7:0];
                tx_last  = (pix_cnt_q == LAST_PIX);
            end
            default: ;
        endcase
    end

endmodule
